// File: rtl/pipe_pkg.sv
// Shared pipeline types: handshake state encoding, per-boundary payload structs
// and the masks naming which payload bits must read as zero in a bubble.
package pipe_pkg;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fd_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        jump;
    logic        branch;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } de_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } em_payload_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
  } mw_payload_t;

  function automatic de_payload_t de_clear_mask();
    de_payload_t m;
    m           = '0;
    m.reg_write = 1'b1;
    m.mem_write = 1'b1;
    m.mem_read  = 1'b1;
    m.jump      = 1'b1;
    m.branch    = 1'b1;
    return m;
  endfunction

  function automatic em_payload_t em_clear_mask();
    em_payload_t m;
    m           = '0;
    m.reg_write = 1'b1;
    m.mem_write = 1'b1;
    return m;
  endfunction

  function automatic mw_payload_t mw_clear_mask();
    mw_payload_t m;
    m           = '0;
    m.reg_write = 1'b1;
    return m;
  endfunction

  // Fetch/decode carries no side-effecting bits.
  localparam fd_payload_t FD_CLEAR_MASK = '0;
  localparam de_payload_t DE_CLEAR_MASK = de_clear_mask();
  localparam em_payload_t EM_CLEAR_MASK = em_clear_mask();
  localparam mw_payload_t MW_CLEAR_MASK = mw_clear_mask();

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer, and masking of side-effect bits in bubbles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SKID        = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_MASK  = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] main_q;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_t           state_q;
      pipe_state_t           state_d;
      logic [DATA_WIDTH-1:0] skid_q;
      logic                  in_ready_q;
      logic                  in_fire;
      logic                  out_fire;

      assign in_fire  = in_valid & in_ready_q;
      assign out_fire = (state_q != EMPTY) & out_ready;

      always_comb begin
        state_d = state_q;
        case (state_q)
          EMPTY: if (in_fire) state_d = ONE;
          ONE: begin
            if (in_fire && !out_fire)      state_d = TWO;
            else if (!in_fire && out_fire) state_d = EMPTY;
          end
          TWO:     if (out_fire) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end

      // in_ready is a flop tracking the next state, so it never sees out_ready combinationally.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
          main_q     <= RESET_VALUE;
          skid_q     <= RESET_VALUE;
        end else if (flush) begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          in_ready_q <= (state_d != TWO);
          case (state_q)
            EMPTY: if (in_fire) main_q <= in_data;
            ONE: begin
              if (in_fire && out_fire) main_q <= in_data;
              else if (in_fire)        skid_q <= in_data;
            end
            TWO:     if (out_fire) main_q <= skid_q;
            default: ;
          endcase
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != EMPTY);
      assign occupancy = state_q;
    end else begin : g_reg
      logic valid_q;
      logic in_fire;
      logic out_fire;

      assign in_ready = ~valid_q | out_ready;
      assign in_fire  = in_valid & in_ready;
      assign out_fire = valid_q & out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= RESET_VALUE;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
          main_q  <= in_data;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid = valid_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

  // Bubbles keep stale payload but must not carry live control bits downstream.
  assign out_data = out_valid ? main_q : (main_q & ~CLEAR_MASK);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance and one plain
// register instance, directed stimulus with hand-computed expectations.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occupancy;

  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_occupancy;

  int checks   = 0;
  int failures = 0;
  int s_pops   = 0;
  int n_pops   = 0;

  logic [31:0] s_exp[$];
  logic [31:0] n_exp[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_WIDTH (32),
    .SKID       (1),
    .CLEAR_MASK (32'h0000_0001),
    .RESET_VALUE(32'h0)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (s_flush),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data),
    .occupancy(s_occupancy)
  );

  pipe_stage_reg #(
    .DATA_WIDTH (32),
    .SKID       (0),
    .CLEAR_MASK (32'h0000_0001),
    .RESET_VALUE(32'h0)
  ) u_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (n_flush),
    .in_valid (n_in_valid),
    .in_ready (n_in_ready),
    .in_data  (n_in_data),
    .out_valid(n_out_valid),
    .out_ready(n_out_ready),
    .out_data (n_out_data),
    .occupancy(n_occupancy)
  );

  // Skid-instance monitor: output pops are compared before same-cycle input pushes.
  always @(negedge clk) begin
    if (rst || s_flush) begin
      s_exp.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        checks++;
        s_pops++;
        if (s_exp.size() == 0) begin
          failures++;
          $display("[TB] FAIL skid_unexpected_out: got %h, expected no output", s_out_data);
        end else begin
          logic [31:0] e;
          e = s_exp.pop_front();
          if (s_out_data !== e) begin
            failures++;
            $display("[TB] FAIL skid_out_order: got %h, expected %h", s_out_data, e);
          end
        end
      end
      if (s_in_valid && s_in_ready) s_exp.push_back(s_in_data);
    end
  end

  always @(negedge clk) begin
    if (rst || n_flush) begin
      n_exp.delete();
    end else begin
      if (n_out_valid && n_out_ready) begin
        checks++;
        n_pops++;
        if (n_exp.size() == 0) begin
          failures++;
          $display("[TB] FAIL reg_unexpected_out: got %h, expected no output", n_out_data);
        end else begin
          logic [31:0] e;
          e = n_exp.pop_front();
          if (n_out_data !== e) begin
            failures++;
            $display("[TB] FAIL reg_out_order: got %h, expected %h", n_out_data, e);
          end
        end
      end
      if (n_in_valid && n_in_ready) n_exp.push_back(n_in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input logic valid, input logic [31:0] data,
                               input logic oready, input logic fl);
    if (sel == 1'b0) begin
      s_in_valid  = valid;
      s_in_data   = data;
      s_out_ready = oready;
      s_flush     = fl;
    end else begin
      n_in_valid  = valid;
      n_in_data   = data;
      n_out_ready = oready;
      n_flush     = fl;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_s_out_valid", {31'b0, s_out_valid}, 32'd0);
    checkOutput("rst_s_occupancy", {30'b0, s_occupancy}, 32'd0);
    checkOutput("rst_s_in_ready",  {31'b0, s_in_ready},  32'd1);
    checkOutput("rst_s_out_data",  s_out_data,           32'h0);
    checkOutput("rst_n_out_valid", {31'b0, n_out_valid}, 32'd0);
    checkOutput("rst_n_in_ready",  {31'b0, n_in_ready},  32'd1);
    checkOutput("rst_n_out_data",  n_out_data,           32'h0);

    $display("[TB] streaming 1..8 through skid stage");
    for (int i = 1; i <= 8; i++) begin
      tick();
      applyStimulus(0, 1'b1, 32'(i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream_in_ready", {31'b0, s_in_ready}, 32'd1);
      if (i == 1) begin
        checkOutput("stream_first_valid", {31'b0, s_out_valid}, 32'd0);
      end else begin
        checkOutput("stream_valid", {31'b0, s_out_valid}, 32'd1);
        checkOutput("stream_data",  s_out_data,           32'(i - 1));
      end
    end
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stream_last_data", s_out_data, 32'd8);
    tick();
    @(negedge clk);
    checkOutput("stream_drained_valid", {31'b0, s_out_valid}, 32'd0);
    checkOutput("stream_drained_occ",   {30'b0, s_occupancy}, 32'd0);

    $display("[TB] filling skid buffer under backpressure");
    tick();
    applyStimulus(0, 1'b1, 32'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'd6, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_occ_one",  {30'b0, s_occupancy}, 32'd1);
    checkOutput("bp_data_one", s_out_data,           32'd5);
    tick();
    applyStimulus(0, 1'b1, 32'd7, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("bp_occ_two",   {30'b0, s_occupancy}, 32'd2);
      checkOutput("bp_in_ready",  {31'b0, s_in_ready},  32'd0);
      checkOutput("bp_data_head", s_out_data,           32'd5);
      tick();
    end
    applyStimulus(0, 1'b1, 32'd7, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_release_data",  s_out_data,          32'd5);
    checkOutput("bp_release_ready", {31'b0, s_in_ready}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("bp_second_data",  s_out_data,           32'd6);
    checkOutput("bp_second_ready", {31'b0, s_in_ready},  32'd1);
    checkOutput("bp_second_occ",   {30'b0, s_occupancy}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_third_data", s_out_data, 32'd7);
    tick();
    @(negedge clk);
    checkOutput("bp_empty_occ", {30'b0, s_occupancy}, 32'd0);

    $display("[TB] flush while holding two entries");
    tick();
    applyStimulus(0, 1'b1, 32'd10, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'd11, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush2_pre_occ", {30'b0, s_occupancy}, 32'd2);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush2_valid",    {31'b0, s_out_valid}, 32'd0);
    checkOutput("flush2_occ",      {30'b0, s_occupancy}, 32'd0);
    checkOutput("flush2_in_ready", {31'b0, s_in_ready},  32'd1);
    tick();
    @(negedge clk);
    checkOutput("flush2_still_empty", {31'b0, s_out_valid}, 32'd0);

    $display("[TB] flush with a live input handshake");
    tick();
    applyStimulus(0, 1'b1, 32'd12, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush1_in_ready", {31'b0, s_in_ready},  32'd1);
    checkOutput("flush1_pre_occ",  {30'b0, s_occupancy}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush1_valid", {31'b0, s_out_valid}, 32'd0);
    checkOutput("flush1_occ",   {30'b0, s_occupancy}, 32'd0);
    checkOutput("flush1_hold",  s_out_data,           32'h0000_000C);
    tick();
    @(negedge clk);
    checkOutput("flush1_still_empty", {31'b0, s_out_valid}, 32'd0);

    $display("[TB] clear mask on drained bubble");
    tick();
    applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mask_valid_data", s_out_data, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    checkOutput("mask_bubble_valid", {31'b0, s_out_valid}, 32'd0);
    checkOutput("mask_bubble_data",  s_out_data,           32'hFFFF_FFFE);

    $display("[TB] plain register stall and replace");
    tick();
    applyStimulus(1, 1'b1, 32'h0000_00A3, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reg_idle_ready", {31'b0, n_in_ready},  32'd1);
    checkOutput("reg_idle_valid", {31'b0, n_out_valid}, 32'd0);
    tick();
    applyStimulus(1, 1'b1, 32'h0000_00B5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("reg_stall_ready", {31'b0, n_in_ready},  32'd0);
      checkOutput("reg_stall_valid", {31'b0, n_out_valid}, 32'd1);
      checkOutput("reg_stall_data",  n_out_data,           32'h0000_00A3);
      checkOutput("reg_stall_occ",   {30'b0, n_occupancy}, 32'd1);
      tick();
    end
    applyStimulus(1, 1'b1, 32'h0000_00B5, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reg_release_ready", {31'b0, n_in_ready}, 32'd1);
    checkOutput("reg_release_data",  n_out_data,          32'h0000_00A3);
    tick();
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reg_replace_valid", {31'b0, n_out_valid}, 32'd1);
    checkOutput("reg_replace_data",  n_out_data,           32'h0000_00B5);
    tick();
    @(negedge clk);
    checkOutput("reg_bubble_valid", {31'b0, n_out_valid}, 32'd0);
    checkOutput("reg_bubble_data",  n_out_data,           32'h0000_00B4);
    checkOutput("reg_bubble_occ",   {30'b0, n_occupancy}, 32'd0);

    $display("[TB] plain register flush with live handshakes");
    tick();
    applyStimulus(1, 1'b1, 32'h0000_00C7, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b1, 32'd9, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("reg_flush_pre_valid", {31'b0, n_out_valid}, 32'd1);
    tick();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reg_flush_valid", {31'b0, n_out_valid}, 32'd0);
    checkOutput("reg_flush_occ",   {30'b0, n_occupancy}, 32'd0);
    checkOutput("reg_flush_data",  n_out_data,           32'h0000_00C6);

    tick();
    @(negedge clk);
    checkOutput("skid_total_outputs", 32'(s_pops), 32'd12);
    checkOutput("reg_total_outputs",  32'(n_pops), 32'd2);
    checkOutput("skid_queue_left",    32'(s_exp.size()), 32'd0);
    checkOutput("reg_queue_left",     32'(n_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
